weight_mem_ctrl: RTL and testbench

- Sequencer in front of the 8-entry weight memory.
- Phase 1 (load): accepts a byte stream over valid/ready and writes it into the memory, one byte per accepted beat, addresses 0..MEM_DEPTH-1.
- Phase 2 (stream): steps the memory read address in groups of GROUP and presents each 4-weight tile to the systolic array with a valid/ready handshake.
- Sits between the host/input shifter and the weight memory / array feed.

---
 rtl/tpu_pkg.sv | 8 +
 rtl/wmc_addr_gen.sv | 42 ++++
 rtl/weight_mem_ctrl.sv | 92 +++++++++
 tb/tb_weight_mem_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared state encoding and sizing for the weight memory controller.
package tpu_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} wmc_state_t;
    localparam int WEIGHT_DEPTH = 8;
    localparam int WEIGHT_GROUP = 4;
    localparam int WEIGHT_W     = 8;
    localparam int ADDR_W       = 16;
endpackage

// File: rtl/wmc_addr_gen.sv
// wmc_addr_gen: tile read-address stepper with one-cycle read bubble.
// Optional WMC_LOOP_EN wraps the address and streams until a stop request.
module wmc_addr_gen import tpu_pkg::*; #(
    parameter int MEM_DEPTH = WEIGHT_DEPTH,
    parameter int GROUP     = WEIGHT_GROUP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              active,
    input  logic              tile_ready,
    input  logic              stop,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              tile_valid,
    output logic              fin
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - GROUP);
    logic fire, last;
    assign fire = tile_valid & tile_ready;
    assign last = mem_raddr == LAST;
`ifdef WMC_LOOP_EN
    logic stop_pend;
    assign fin = fire & (stop_pend | stop);
    always_ff @(posedge clk)
        if (rst || start) stop_pend <= 1'b0;
        else if (active && stop) stop_pend <= 1'b1;
`else
    logic unused_stop;
    assign unused_stop = stop;
    assign fin = fire & last;
`endif
    // Memory data lags the address by a cycle, so a fresh address always costs one invalid cycle.
    always_ff @(posedge clk)
        if (rst) begin
            mem_raddr  <= '0;
            tile_valid <= 1'b0;
        end else begin
            tile_valid <= active & ~fire;
            if (start) mem_raddr <= '0;
            else if (fire && !fin) mem_raddr <= last ? '0 : mem_raddr + ADDR_W'(GROUP);
        end
endmodule

// File: rtl/weight_mem_ctrl.sv
// weight_mem_ctrl: loads a weight byte stream into memory, then streams 4-weight tiles to the array.
// Build with WMC_LOOP_EN for a continuously looping stream ended by cmd_stop.
module weight_mem_ctrl import tpu_pkg::*; #(
    parameter int MEM_DEPTH = WEIGHT_DEPTH,
    parameter int GROUP     = WEIGHT_GROUP,
    parameter int DATA_W    = WEIGHT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_load,
    input  logic              cmd_run,
    input  logic              cmd_stop,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic              busy,
    output logic              loaded,
    output logic              done
);
    localparam int CW = $clog2(MEM_DEPTH);
    wmc_state_t    state;
    logic [CW-1:0] wcnt;
    logic          start, fin;
    assign start = state == IDLE && cmd_run && !cmd_load && loaded;
    wmc_addr_gen #(.MEM_DEPTH(MEM_DEPTH), .GROUP(GROUP)) u_addr (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .active     (state == STREAM),
        .tile_ready (tile_ready),
        .stop       (cmd_stop),
        .mem_raddr  (mem_raddr),
        .tile_valid (tile_valid),
        .fin        (fin)
    );
    always_ff @(posedge clk)
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            loaded    <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE:
                    if (cmd_load) begin
                        state    <= LOAD;
                        wcnt     <= '0;
                        loaded   <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end else if (start) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                LOAD:
                    if (in_valid && in_ready) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= ADDR_W'(wcnt);
                        mem_wdata <= in_data;
                        wcnt      <= wcnt + 1'b1;
                        if (&wcnt) begin
                            state    <= IDLE;
                            loaded   <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                STREAM:
                    if (fin) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_weight_mem_ctrl.sv
// tb_weight_mem_ctrl: scoreboard bench for weight_mem_ctrl; expected writes and tiles are queued by stimulus.
module tb_weight_mem_ctrl;
    import tpu_pkg::*;
    localparam int D = WEIGHT_DEPTH;
    localparam int G = WEIGHT_GROUP;
    logic clk = 0, rst = 1, cmd_load = 0, cmd_run = 0, cmd_stop = 0, in_valid = 0, tile_ready = 0;
    logic [7:0] in_data = 0;
    logic in_ready, mem_we, tile_valid, busy, loaded, done;
    logic [15:0] mem_waddr, mem_raddr;
    logic [7:0] mem_wdata;
    int checks = 0, fails = 0;
    logic [23:0] wq[$];
    logic [15:0] tq[$];
    bit prev_fire = 0;

    weight_mem_ctrl dut (
        .clk(clk), .rst(rst), .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .busy(busy), .loaded(loaded), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected writes on mem_we and expected tiles on each fire.
    always @(negedge clk) begin
        if (rst) prev_fire = 0;
        else begin
            if (prev_fire) chk("bubble_after_fire", tile_valid, 0);
            if (mem_we) begin
                chk("write_expected", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    logic [23:0] w;
                    w = wq.pop_front();
                    chk("mem_waddr", mem_waddr, w[23:8]);
                    chk("mem_wdata", mem_wdata, w[7:0]);
                end
            end
            if (tile_valid) begin
                chk("tile_expected", 32'(tq.size() != 0), 1);
                if (tq.size() != 0) begin
                    chk("tile_raddr", mem_raddr, tq[0]);
                    if (tile_ready) void'(tq.pop_front());
                end
            end
            prev_fire = tile_valid & tile_ready;
        end
    end

    task automatic load_all(bit gaps, bit directed);
        logic [7:0] d;
        cmd_load = 1;
        step;
        cmd_load = 0;
        chk("in_ready_load", in_ready, 1);
        chk("loaded_cleared", loaded, 0);
        for (int i = 0; i < D; i++) begin
            if (gaps)
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 0;
                    in_data = 8'($urandom);
                    step;
                end
            d = directed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            in_valid = 1;
            in_data = d;
            wq.push_back({16'(i), d});
            step;
        end
        in_data = 8'hee;
        chk("in_ready_after_last", in_ready, 0);
        chk("loaded_set", loaded, 1);
        step;
        in_valid = 0;
        chk("writes_left", wq.size(), 0);
    endtask

    task automatic wait_done(bit rnd);
        int n = 0;
        while (!done && n < 200) begin
            if (rnd) tile_ready = 1'($urandom_range(0, 1));
            step;
            n++;
        end
        chk("done_seen", done, 1);
        chk("tiles_left", tq.size(), 0);
        step;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic push_set;
        for (int a = 0; a <= D - G; a += G) tq.push_back(16'(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] e_tv, e_done, e_busy;
        e_tv = 6'b001010;
        e_done = 6'b010000;
        e_busy = 6'b011111;
        step;
        step;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_waddr", mem_waddr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_raddr", mem_raddr, 0);
        chk("rst_tile_valid", tile_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_done", done, 0);
        rst = 0;
        cmd_run = 1;
        step;
        cmd_run = 0;
        chk("run_unloaded_busy", busy, 0);
        load_all(0, 1);
`ifndef WMC_LOOP_EN
        push_set();
        cmd_run = 1;
        cmd_stop = 1;
        tile_ready = 1;
        step;
        cmd_run = 0;
        for (int k = 0; k < 6; k++) begin
            chk("t3_tile_valid", tile_valid, e_tv[k]);
            chk("t3_raddr", mem_raddr, k < 2 ? 0 : G);
            chk("t3_done", done, e_done[k]);
            chk("t3_busy", busy, e_busy[k]);
            if (k < 5) step;
        end
        cmd_stop = 0;
        chk("t3_tiles_left", tq.size(), 0);
        push_set();
        tile_ready = 0;
        cmd_run = 1;
        step;
        cmd_run = 0;
        for (int k = 0; k < 3; k++) begin
            step;
            chk("t4_hold_valid", tile_valid, 1);
            chk("t4_hold_raddr", mem_raddr, 0);
        end
        tile_ready = 1;
        step;
        chk("t4_advance_raddr", mem_raddr, G);
        chk("t4_advance_valid", tile_valid, 0);
        wait_done(0);
`endif
        cmd_load = 1;
        step;
        cmd_load = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1;
            in_data = 8'($urandom);
            wq.push_back({16'(i), in_data});
            step;
        end
        in_valid = 0;
        step;
        rst = 1;
        step;
        rst = 0;
        chk("t5_loaded", loaded, 0);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_busy", busy, 0);
        chk("t5_writes_left", wq.size(), 0);
        cmd_run = 1;
        step;
        cmd_run = 0;
        chk("t5_run_ignored", busy, 0);
        step;
        chk("t5_no_tile", tile_valid, 0);
        load_all(1, 0);
`ifndef WMC_LOOP_EN
        for (int r = 0; r < 4; r++) begin
            push_set();
            cmd_run = 1;
            tile_ready = 1'($urandom_range(0, 1));
            step;
            cmd_run = 0;
            chk("rnd_busy", busy, 1);
            wait_done(1);
            if (r == 1) load_all(1, 0);
        end
`else
        for (int k = 0; k < 5; k++) tq.push_back(16'((k % 2) * G));
        tile_ready = 1;
        cmd_run = 1;
        step;
        cmd_run = 0;
        repeat (9) step;
        chk("t6_tile5_valid", tile_valid, 1);
        chk("t6_tile5_raddr", mem_raddr, 0);
        cmd_stop = 1;
        step;
        cmd_stop = 0;
        chk("t6_done", done, 1);
        chk("t6_tiles_left", tq.size(), 0);
        step;
        chk("t6_done_pulse", done, 0);
        chk("t6_busy", busy, 0);
`endif
        chk("final_writes_left", wq.size(), 0);
        chk("final_tiles_left", tq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
